// File: rtl/sha256_msg_sequencer.sv
// Byte-stream front end for a SHA-256 compression core: assembles 512-bit blocks,
// appends FIPS 180-4 padding and forwards only the final digest of each message.
module sha256_msg_sequencer #(
    parameter int LEN_W = 61
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [7:0]   in_data,
    input  logic         in_last,
    input  logic         msg_empty,
    output logic         core_blk_valid,
    input  logic         core_blk_ready,
    output logic [511:0] core_blk_data,
    output logic         core_start_new_msg,
    input  logic         core_digest_valid,
    output logic         core_digest_ready,
    input  logic [255:0] core_digest,
    output logic         digest_valid,
    input  logic         digest_ready,
    output logic [255:0] digest,
    output logic         busy
);

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_LOAD     = 3'd1,
        S_PAD      = 3'd2,
        S_SEND     = 3'd3,
        S_WAIT_DIG = 3'd4,
        S_OUT      = 3'd5
    } state_t;

    localparam logic [LEN_W-1:0] CNT_ONE = {{(LEN_W-1){1'b0}}, 1'b1};

    // Byte j lives in word j/4 at [32k+:32], big-endian inside the word.
    function automatic logic [511:0] put_byte(input logic [511:0] blk, input logic [5:0] idx,
                                              input logic [7:0] val);
        logic [511:0] res;
        logic [8:0]   ofs;
        res = blk;
        ofs = {idx[5:2], 5'b00000} + {4'b0000, ~idx[1:0], 3'b000};
        res[ofs +: 8] = val;
        return res;
    endfunction

    state_t             state_r, state_s;
    logic [5:0]         ptr_r, ptr_s;
    logic [LEN_W-1:0]   cnt_r, cnt_s;
    logic [511:0]       blk_r, blk_s;
    logic [255:0]       digest_r, digest_s;
    logic               pad80_r, pad80_s;
    logic               len_done_r, len_done_s;
    logic               first_blk_r, first_blk_s;
    logic               last_seen_r, last_seen_s;
    logic               len_defer_r, len_defer_s;
    logic               in_ready_r, in_ready_s;
    logic               blk_valid_r, blk_valid_s;
    logic               start_r, start_s;
    logic               dig_ready_r, dig_ready_s;
    logic               digest_valid_r, digest_valid_s;
    logic               busy_r, busy_s;
    logic               accept_s;
    logic [63:0]        bit_len_s;
    logic [7:0]         len_byte_s;

    assign accept_s   = in_valid && in_ready_r;
    assign bit_len_s  = 64'(cnt_r) << 3'd3;
    assign len_byte_s = bit_len_s[{~ptr_r[2:0], 3'b000} +: 8];

    // Next-state, datapath updates and next values of the registered outputs.
    always_comb begin
        state_s     = state_r;
        ptr_s       = ptr_r;
        cnt_s       = cnt_r;
        blk_s       = blk_r;
        digest_s    = digest_r;
        pad80_s     = pad80_r;
        len_done_s  = len_done_r;
        first_blk_s = first_blk_r;
        last_seen_s = last_seen_r;
        len_defer_s = len_defer_r;
        case (state_r)
            S_IDLE: begin
                if (accept_s) begin
                    blk_s       = put_byte(blk_r, 6'd0, in_data);
                    ptr_s       = 6'd1;
                    cnt_s       = CNT_ONE;
                    first_blk_s = 1'b1;
                    last_seen_s = in_last;
                    state_s     = in_last ? S_PAD : S_LOAD;
                end else if (msg_empty && !in_valid) begin
                    first_blk_s = 1'b1;
                    state_s     = S_PAD;
                end else begin
                    state_s = S_IDLE;
                end
            end
            S_LOAD: begin
                if (accept_s) begin
                    blk_s = put_byte(blk_r, ptr_r, in_data);
                    ptr_s = ptr_r + 6'd1;
                    cnt_s = cnt_r + CNT_ONE;
                    if (ptr_r == 6'd63) begin
                        last_seen_s = last_seen_r | in_last;
                        state_s     = S_SEND;
                    end else if (in_last) begin
                        last_seen_s = 1'b1;
                        state_s     = S_PAD;
                    end else begin
                        state_s = S_LOAD;
                    end
                end else begin
                    state_s = S_LOAD;
                end
            end
            S_PAD: begin
                ptr_s = ptr_r + 6'd1;
                if (!pad80_r) begin
                    blk_s       = put_byte(blk_r, ptr_r, 8'h80);
                    pad80_s     = 1'b1;
                    len_defer_s = (ptr_r >= 6'd56);
                end else if (ptr_r < 6'd56) begin
                    blk_s = put_byte(blk_r, ptr_r, 8'h00);
                end else if (len_defer_r) begin
                    // Marker took the length slots: finish this block with zeros.
                    blk_s = put_byte(blk_r, ptr_r, 8'h00);
                end else begin
                    blk_s      = put_byte(blk_r, ptr_r, len_byte_s);
                    len_done_s = (ptr_r == 6'd63);
                end
                if (ptr_r == 6'd63) begin
                    state_s = S_SEND;
                end else begin
                    state_s = S_PAD;
                end
            end
            S_SEND: begin
                if (core_blk_ready) begin
                    ptr_s       = 6'd0;
                    blk_s       = 512'd0;
                    first_blk_s = 1'b0;
                    len_defer_s = 1'b0;
                    state_s     = S_WAIT_DIG;
                end else begin
                    state_s = S_SEND;
                end
            end
            S_WAIT_DIG: begin
                if (core_digest_valid) begin
                    if (len_done_r) begin
                        digest_s = core_digest;
                        state_s  = S_OUT;
                    end else if (last_seen_r || pad80_r) begin
                        state_s = S_PAD;
                    end else begin
                        state_s = S_LOAD;
                    end
                end else begin
                    state_s = S_WAIT_DIG;
                end
            end
            S_OUT: begin
                if (digest_ready) begin
                    pad80_s     = 1'b0;
                    len_done_s  = 1'b0;
                    first_blk_s = 1'b0;
                    last_seen_s = 1'b0;
                    len_defer_s = 1'b0;
                    cnt_s       = {LEN_W{1'b0}};
                    state_s     = S_IDLE;
                end else begin
                    state_s = S_OUT;
                end
            end
            default: begin
                state_s = S_IDLE;
            end
        endcase
        in_ready_s     = (state_s == S_IDLE) || (state_s == S_LOAD);
        blk_valid_s    = (state_s == S_SEND);
        start_s        = (state_s == S_SEND) && first_blk_s;
        dig_ready_s    = (state_s == S_WAIT_DIG);
        digest_valid_s = (state_s == S_OUT);
        busy_s         = (state_s != S_IDLE);
    end

    // State, datapath and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r        <= S_IDLE;
            ptr_r          <= 6'd0;
            cnt_r          <= {LEN_W{1'b0}};
            blk_r          <= 512'd0;
            digest_r       <= 256'd0;
            pad80_r        <= 1'b0;
            len_done_r     <= 1'b0;
            first_blk_r    <= 1'b0;
            last_seen_r    <= 1'b0;
            len_defer_r    <= 1'b0;
            in_ready_r     <= 1'b0;
            blk_valid_r    <= 1'b0;
            start_r        <= 1'b0;
            dig_ready_r    <= 1'b0;
            digest_valid_r <= 1'b0;
            busy_r         <= 1'b0;
        end else begin
            state_r        <= state_s;
            ptr_r          <= ptr_s;
            cnt_r          <= cnt_s;
            blk_r          <= blk_s;
            digest_r       <= digest_s;
            pad80_r        <= pad80_s;
            len_done_r     <= len_done_s;
            first_blk_r    <= first_blk_s;
            last_seen_r    <= last_seen_s;
            len_defer_r    <= len_defer_s;
            in_ready_r     <= in_ready_s;
            blk_valid_r    <= blk_valid_s;
            start_r        <= start_s;
            dig_ready_r    <= dig_ready_s;
            digest_valid_r <= digest_valid_s;
            busy_r         <= busy_s;
        end
    end

    assign in_ready           = in_ready_r;
    assign core_blk_valid     = blk_valid_r;
    assign core_blk_data      = blk_r;
    assign core_start_new_msg = start_r;
    assign core_digest_ready  = dig_ready_r;
    assign digest_valid       = digest_valid_r;
    assign digest             = digest_r;
    assign busy               = busy_r;

endmodule

// File: tb/tb_sha256_msg_sequencer.sv
// Scoreboard bench: a SHA-256 core model answers block requests, a padding reference
// model predicts blocks and final digests, monitors compare what the sequencer presents.
module tb_sha256_msg_sequencer;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_last, msg_empty;
    logic [7:0]   in_data;
    logic         core_blk_valid, core_blk_ready, core_start_new_msg;
    logic [511:0] core_blk_data;
    logic         core_digest_valid, core_digest_ready;
    logic [255:0] core_digest;
    logic         digest_valid, digest_ready, busy;
    logic [255:0] digest;

    sha256_msg_sequencer dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
        .msg_empty(msg_empty),
        .core_blk_valid(core_blk_valid), .core_blk_ready(core_blk_ready),
        .core_blk_data(core_blk_data), .core_start_new_msg(core_start_new_msg),
        .core_digest_valid(core_digest_valid), .core_digest_ready(core_digest_ready),
        .core_digest(core_digest),
        .digest_valid(digest_valid), .digest_ready(digest_ready), .digest(digest),
        .busy(busy)
    );

    always #5 clk = ~clk;

    localparam logic [255:0] IV = 256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
    localparam logic [255:0] ABC_DIG = 256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
    localparam logic [255:0] EMPTY_DIG = 256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
    localparam logic [31:0] K_TAB [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    typedef struct packed {
        logic [511:0] data;
        logic         start;
    } blk_exp_t;

    blk_exp_t     exp_blk[$];
    logic [255:0] exp_dig[$];
    logic [7:0]   msg_q[$];
    int           checks = 0;
    int           failures = 0;
    bit           force_blk_low = 1'b0;
    bit           force_dig_low = 1'b0;

    task automatic chk(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ror(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Word k of a block is at [32k+:32]; chaining value word i at [255-32i -: 32].
    function automatic logic [255:0] sha_compress(input logic [255:0] hin, input logic [511:0] m);
        logic [31:0] w [64];
        logic [31:0] a, b, c, d, e, f, g, h, t1, t2;
        for (int i = 0; i < 16; i++) w[i] = m[32*i +: 32];
        for (int i = 16; i < 64; i++)
            w[i] = w[i-16] + (ror(w[i-15], 7) ^ ror(w[i-15], 18) ^ (w[i-15] >> 3)) + w[i-7]
                 + (ror(w[i-2], 17) ^ ror(w[i-2], 19) ^ (w[i-2] >> 10));
        {a, b, c, d, e, f, g, h} = hin;
        for (int i = 0; i < 64; i++) begin
            t1 = h + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K_TAB[i] + w[i];
            t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
            h = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
        end
        return {hin[255:224] + a, hin[223:192] + b, hin[191:160] + c, hin[159:128] + d,
                hin[127:96] + e, hin[95:64] + f, hin[63:32] + g, hin[31:0] + h};
    endfunction

    // Reference: standard padding of msg_q, split into blocks, expected final digest.
    task automatic build_expect(input bit kat, input logic [255:0] kat_dig);
        logic [7:0]   p[$];
        logic [63:0]  bitlen;
        logic [511:0] blk;
        logic [255:0] h;
        p = msg_q;
        p.push_back(8'h80);
        while (p.size() % 64 != 56) p.push_back(8'h00);
        bitlen = 64'(msg_q.size()) * 64'd8;
        for (int i = 7; i >= 0; i--) p.push_back(bitlen[8*i +: 8]);
        h = IV;
        for (int b = 0; b < p.size() / 64; b++) begin
            blk = '0;
            for (int k = 0; k < 16; k++)
                blk[32*k +: 32] = {p[64*b+4*k], p[64*b+4*k+1], p[64*b+4*k+2], p[64*b+4*k+3]};
            exp_blk.push_back('{data: blk, start: (b == 0)});
            h = sha_compress(h, blk);
        end
        exp_dig.push_back(kat ? kat_dig : h);
    endtask

    // Block monitor: scoreboard compare on handshake, stability and in_ready while stalled.
    logic [511:0] pb_data;
    logic         pb_start;
    bit           pb_stall = 1'b0;
    blk_exp_t     eb;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pb_stall = 1'b0;
            end else if (core_blk_valid) begin
                chk("in_ready_while_send", in_ready, 1'b0);
                if (pb_stall) begin
                    chk("blk_data_stable", core_blk_data, pb_data);
                    chk("blk_start_stable", core_start_new_msg, pb_start);
                end
                if (core_blk_ready) begin
                    pb_stall = 1'b0;
                    if (exp_blk.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL unexpected_block: got %0h expected none", core_blk_data);
                    end else begin
                        eb = exp_blk.pop_front();
                        chk("blk_data", core_blk_data, eb.data);
                        chk("blk_start_new_msg", core_start_new_msg, eb.start);
                    end
                end else begin
                    pb_stall = 1'b1;
                    pb_data  = core_blk_data;
                    pb_start = core_start_new_msg;
                end
            end else begin
                pb_stall = 1'b0;
            end
        end
    end

    // Digest monitor: scoreboard compare, stability under backpressure, valid drop.
    logic [255:0] pd_dig;
    bit           pd_stall = 1'b0;
    bit           pd_hs = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            if (rst) begin
                pd_stall = 1'b0;
                pd_hs    = 1'b0;
            end else begin
                if (pd_hs) chk("digest_valid_drop", digest_valid, 1'b0);
                pd_hs = 1'b0;
                if (digest_valid) begin
                    if (pd_stall) chk("digest_stable", digest, pd_dig);
                    if (digest_ready) begin
                        pd_stall = 1'b0;
                        pd_hs    = 1'b1;
                        if (exp_dig.size() == 0) begin
                            checks++; failures++;
                            $display("FAIL unexpected_digest: got %0h expected none", digest);
                        end else begin
                            chk("digest", digest, exp_dig.pop_front());
                        end
                    end else begin
                        chk("busy_while_out", busy, 1'b1);
                        pd_stall = 1'b1;
                        pd_dig   = digest;
                    end
                end else begin
                    pd_stall = 1'b0;
                end
            end
        end
    end

    // Compression core model with random ready and latency.
    logic [255:0] core_h;
    logic [511:0] cm_data;
    logic         cm_start, cm_bhs, cm_dhs, cm_pend;
    int           cm_wait;
    initial begin
        core_blk_ready = 1'b0; core_digest_valid = 1'b0; core_digest = '0;
        core_h = IV; cm_pend = 1'b0; cm_wait = 0;
        forever begin
            @(negedge clk);
            cm_bhs   = core_blk_valid && core_blk_ready;
            cm_dhs   = core_digest_valid && core_digest_ready;
            cm_data  = core_blk_data;
            cm_start = core_start_new_msg;
            @(posedge clk); #1;
            if (rst) begin
                core_digest_valid = 1'b0;
                cm_pend = 1'b0;
            end else begin
                if (cm_dhs) core_digest_valid = 1'b0;
                if (cm_bhs) begin
                    core_h  = sha_compress(cm_start ? IV : core_h, cm_data);
                    cm_pend = 1'b1;
                    cm_wait = int'($urandom_range(0, 3));
                end else if (cm_pend) begin
                    if (cm_wait == 0) begin
                        core_digest_valid = 1'b1;
                        core_digest = core_h;
                        cm_pend = 1'b0;
                    end else begin
                        cm_wait--;
                    end
                end
            end
            core_blk_ready = !force_blk_low && ($urandom_range(0, 3) != 0);
        end
    end

    // Downstream digest consumer.
    initial begin
        digest_ready = 1'b0;
        forever begin
            @(posedge clk); #1;
            digest_ready = !force_dig_low && ($urandom_range(0, 2) != 0);
        end
    end

    task automatic send_byte(input logic [7:0] d, input bit last, input bit with_empty);
        int t;
        int gap;
        gap = int'($urandom_range(0, 2));
        if (gap > 0) begin
            in_valid = 1'b0;
            repeat (gap) begin @(posedge clk); #1; end
        end
        in_valid = 1'b1; in_data = d; in_last = last; msg_empty = with_empty;
        t = 0;
        do begin @(negedge clk); t++; end while (!in_ready && t < 3000);
        if (!in_ready) begin
            checks++; failures++;
            $display("FAIL in_ready_timeout: got 0 expected 1");
        end
        @(posedge clk); #1;
        msg_empty = 1'b0;
    endtask

    task automatic send_msg(input bit with_empty);
        @(posedge clk); #1;
        for (int i = 0; i < msg_q.size(); i++)
            send_byte(msg_q[i], i == msg_q.size() - 1, with_empty && i == 0);
        in_valid = 1'b0; in_last = 1'b0; msg_empty = 1'b0;
    endtask

    task automatic pulse_empty();
        @(posedge clk); #1; msg_empty = 1'b1;
        @(posedge clk); #1; msg_empty = 1'b0;
    endtask

    task automatic wait_idle();
        int t;
        t = 0;
        while ((exp_blk.size() != 0 || exp_dig.size() != 0 || busy) && t < 4000) begin
            @(negedge clk); t++;
        end
        if (t >= 4000) begin
            checks++; failures++;
            $display("FAIL idle_timeout: got blk=%0d dig=%0d busy=%0b expected 0 0 0",
                     exp_blk.size(), exp_dig.size(), busy);
            exp_blk.delete(); exp_dig.delete();
        end
    endtask

    task automatic fill_random(input int n);
        msg_q.delete();
        for (int i = 0; i < n; i++) msg_q.push_back(8'($urandom_range(0, 255)));
    endtask

    task automatic run_abc();
        msg_q.delete();
        msg_q.push_back(8'h61); msg_q.push_back(8'h62); msg_q.push_back(8'h63);
        build_expect(1'b1, ABC_DIG);
        send_msg(1'b0);
        wait_idle();
    endtask

    task automatic run_rand(input int n, input bit with_empty);
        fill_random(n);
        build_expect(1'b0, 256'd0);
        if (n == 0) pulse_empty();
        else send_msg(with_empty);
        wait_idle();
    endtask

    task automatic check_zero_outputs(input string tag);
        chk({tag, "_in_ready"}, in_ready, 1'b0);
        chk({tag, "_blk_valid"}, core_blk_valid, 1'b0);
        chk({tag, "_blk_data"}, core_blk_data, 512'd0);
        chk({tag, "_start"}, core_start_new_msg, 1'b0);
        chk({tag, "_dig_ready"}, core_digest_ready, 1'b0);
        chk({tag, "_digest_valid"}, digest_valid, 1'b0);
        chk({tag, "_digest"}, digest, 256'd0);
        chk({tag, "_busy"}, busy, 1'b0);
    endtask

    initial begin
        int t;
        rst = 1'b1; in_valid = 1'b0; in_data = 8'h00; in_last = 1'b0; msg_empty = 1'b0;
        #22;
        check_zero_outputs("reset");
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        chk("in_ready_after_reset", in_ready, 1'b1);
        chk("busy_after_reset", busy, 1'b0);

        run_abc();
        msg_q.delete();
        build_expect(1'b1, EMPTY_DIG);
        pulse_empty();
        wait_idle();
        run_rand(56, 1'b0);
        run_rand(64, 1'b0);
        run_rand(55, 1'b0);
        run_rand(63, 1'b0);
        run_rand(119, 1'b0);
        run_rand(128, 1'b0);
        run_rand(5, 1'b1);

        // Core stalls the block handshake for 10 cycles.
        force_blk_low = 1'b1;
        fill_random(10);
        build_expect(1'b0, 256'd0);
        send_msg(1'b0);
        t = 0;
        while (!core_blk_valid && t < 500) begin @(negedge clk); t++; end
        repeat (10) @(negedge clk);
        chk("blk_held_under_backpressure", core_blk_valid, 1'b1);
        force_blk_low = 1'b0;
        wait_idle();

        // Downstream stalls the digest for 5 cycles.
        force_dig_low = 1'b1;
        fill_random(70);
        build_expect(1'b0, 256'd0);
        send_msg(1'b0);
        t = 0;
        while (!digest_valid && t < 2000) begin @(negedge clk); t++; end
        repeat (5) @(negedge clk);
        chk("digest_held_under_backpressure", digest_valid, 1'b1);
        chk("busy_held_under_backpressure", busy, 1'b1);
        force_dig_low = 1'b0;
        wait_idle();

        for (int i = 0; i < 8; i++) run_rand(int'($urandom_range(0, 150)), 1'b0);

        // Abort a message mid-LOAD after 20 bytes.
        fill_random(20);
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) send_byte(msg_q[i], 1'b0, 1'b0);
        in_valid = 1'b0;
        chk("busy_in_load", busy, 1'b1);
        #2 rst = 1'b1;
        #1 check_zero_outputs("midload_reset");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        run_abc();

        wait_idle();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sha256_msg_sequencer.md
Name: sha256_msg_sequencer

Overview:
Front-end controller for the SHA-256 compression core. It accepts a message as a byte stream, builds each 512-bit block, and applies FIPS 180-4 padding: a 0x80 byte, zero fill, and a 64-bit big-endian bit length. It presents each block to the core's blk_valid/blk_ready/start_new_msg interface and absorbs the core's per-block digest handshake. It forwards only the final digest of each message downstream.

Parameters:
LEN_W, 61, width of the message byte counter; bit length = byte count << 3, zero-extended to 64 bits.

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  byte stream valid
in_ready  out  1  sequencer accepts in_data this cycle
in_data  in  8  message byte
in_last  in  1  qualifies in_data as last byte of message
msg_empty  in  1  single-cycle request in IDLE to hash the zero-length message
core_blk_valid  out  1  block valid to core
core_blk_ready  in  1  core accepts block
core_blk_data  out  512  block to core
core_start_new_msg  out  1  high with first block of a message
core_digest_valid  in  1  core finished a block
core_digest_ready  out  1  sequencer accepts core digest
core_digest  in  256  core chaining value / digest
digest_valid  out  1  final message digest valid
digest_ready  in  1  downstream accepts digest
digest  out  256  final digest (H0 in [255:224])
busy  out  1  high in any state except IDLE

Behaviour:
- Reset values: all outputs 0; buffer 0, ptr=0, byte count=0; flags pad80_done, len_done, first_blk cleared. Reset mid-operation aborts the message. No partial digest is emitted afterwards.
- Block layout: byte index j (0..63) of the block maps to word k=j/4 at core_blk_data[32k+:32], big-endian within the word. Byte 4k goes to bits [32k+31:32k+24].
- States: IDLE, LOAD, PAD, SEND, WAIT_DIG, OUT.
- IDLE: in_ready=1.
  - Byte accepted -> write buf[0], ptr=1, count=1, first_blk=1, go to LOAD. If in_last is also high, go to PAD instead.
  - msg_empty (with in_valid low) -> first_blk=1, go to PAD.
  - If in_valid and msg_empty are both high, the byte wins and msg_empty is ignored.
- LOAD: in_ready=1. Each accepted byte is written at ptr; ptr++ and count++.
  - Accept at ptr=63 -> SEND. Record last_seen if in_last.
  - in_last accepted at ptr<63 -> PAD.
- PAD: in_ready=0. Writes one byte per cycle at ptr, ptr++.
  - If !pad80_done: write 0x80 and set pad80_done.
  - Else if ptr<56: write 0x00.
  - Else if the 0x80 byte landed at ptr>=56 of this block (length does not fit): write 0x00 up to 63, then SEND, non-final.
  - Else: write length bytes ptr=56..63, MSB first; at 63 set len_done and go to SEND.
- SEND: core_blk_valid=1. core_blk_data and core_start_new_msg stay stable until core_blk_ready.
  - core_start_new_msg = first_blk; first_blk is cleared on the handshake.
  - On handshake: ptr=0, buffer cleared, go to WAIT_DIG.
- WAIT_DIG: core_digest_ready=1.
  - On core_digest_valid: if len_done, latch core_digest into digest and go to OUT.
  - Else, if last_seen or pad80_done, go to PAD; otherwise go to LOAD.
- OUT: digest_valid=1 and digest held until digest_ready. Then clear all flags and count, go to IDLE. digest_valid drops the cycle after the handshake.
- Byte count wraps modulo 2^LEN_W with no error flag.
- No bypass paths: in_ready never depends combinationally on core_blk_ready or digest_ready.

Test Plan:
- "abc" (0x61,0x62,0x63, in_last on 0x63):
  - One block: word0=0x61626380, words1..14=0, word15=0x00000018, start_new_msg=1.
  - Core model returns real hash -> digest=ba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad.
- msg_empty pulse in IDLE -> one block: word0=0x80000000, others 0 -> digest=e3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855.
- 56-byte message -> two blocks:
  - Block 1: byte56=0x80, bytes57..63=0, start_new_msg=1.
  - Block 2: zeros, word15=0x000001C0, start_new_msg=0.
  - One digest_valid only.
- 64-byte message -> two blocks; block 2 word0=0x80000000, word15=0x00000200.
- Backpressure:
  - core_blk_ready low 10 cycles -> core_blk_data and core_start_new_msg stable, in_ready=0.
  - digest_ready low 5 cycles -> digest stable, busy=1.
- rst asserted mid-LOAD after 20 bytes -> all outputs 0 immediately. A following "abc" message hashes correctly with start_new_msg=1.
